// File: rtl/pic_pkg.sv
// Shared types and constants for the 8259A-style interrupt sequencer.
// A priority rank of 0 is the highest priority, given the current rotation pointer.
package pic_pkg;

    localparam int LEVEL_W    = 3;
    localparam int NUM_LEVELS = 8;

    localparam logic [LEVEL_W-1:0] SPURIOUS_LEVEL = 3'd7;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_INTA1,
        WAIT_INTA2
    } state_t;

    // Maps a level to its rank. The level just above the pointer gets rank 0.
    function automatic logic [LEVEL_W-1:0] priority_rank(
        input logic [LEVEL_W-1:0] level,
        input logic [LEVEL_W-1:0] lowest_priority
    );
        return level - lowest_priority - 3'd1;
    endfunction

endpackage

// File: rtl/priority_resolver.sv
// Rotating-priority encoder. It scans upward from (lowest_priority + 1), wrapping around,
// and returns the first set bit it finds.
module priority_resolver
    import pic_pkg::*;
(
    input  logic [NUM_LEVELS-1:0] req,
    input  logic [LEVEL_W-1:0]    lowest_priority,
    output logic                  found,
    output logic [LEVEL_W-1:0]    level
);

    always_comb begin
        logic [LEVEL_W-1:0] idx;
        found = 1'b0;
        level = '0;
        idx   = '0;
        for (int i = 0; i < NUM_LEVELS; i++) begin
            idx = lowest_priority + LEVEL_W'(i + 1);
            if (!found && req[idx]) begin
                found = 1'b1;
                level = idx;
            end
        end
    end

endmodule

// File: rtl/interrupt_sequencer.sv
// 8259A control block: fully nested priority against the ISR, the INTA1/INTA2 handshake,
// vector delivery, EOI/AEOI handling and optional priority rotation.
module interrupt_sequencer
    import pic_pkg::*;
#(
    parameter int LEVELS = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [LEVELS-1:0] irq,
    input  logic              inta,
    input  logic [4:0]        vectorBase,
    input  logic              autoEoi,
    input  logic              rotateOnAutoEoi,
    input  logic              eoiStrobe,
    input  logic              specificEoi,
    input  logic [2:0]        eoiLevel,
    input  logic              rotateOnEoi,
    output logic              intr,
    output logic [LEVELS-1:0] clearInterruptRequest,
    output logic [LEVELS-1:0] inServiceRegister,
    output logic [7:0]        vector,
    output logic              vectorValid
);

    state_t             state_q, state_d;
    logic               int_q, int_d;
    logic [LEVELS-1:0]  clear_q, clear_d;
    logic [LEVELS-1:0]  isr_q, isr_d;
    logic [7:0]         vector_q, vector_d;
    logic               vector_valid_q, vector_valid_d;
    logic [LEVEL_W-1:0] lowest_q, lowest_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic               spurious_q, spurious_d;

    logic               req_found, ceil_found;
    logic [LEVEL_W-1:0] req_level, ceil_level;
    logic               qualify;
    logic               eoi_hit;
    logic [LEVEL_W-1:0] eoi_target;

    priority_resolver u_req_resolver (
        .req             (irq),
        .lowest_priority (lowest_q),
        .found           (req_found),
        .level           (req_level)
    );

    priority_resolver u_isr_resolver (
        .req             (isr_q),
        .lowest_priority (lowest_q),
        .found           (ceil_found),
        .level           (ceil_level)
    );

    assign qualify = req_found &&
                     (!ceil_found ||
                      (priority_rank(req_level, lowest_q) < priority_rank(ceil_level, lowest_q)));

    // A non-specific EOI with an empty ISR has no target, so it neither clears nor rotates.
    assign eoi_hit    = eoiStrobe && (specificEoi || ceil_found);
    assign eoi_target = specificEoi ? eoiLevel : ceil_level;

    always_comb begin
        state_d        = state_q;
        int_d          = int_q;
        clear_d        = '0;
        isr_d          = isr_q;
        vector_d       = vector_q;
        vector_valid_d = 1'b0;
        lowest_d       = lowest_q;
        level_d        = level_q;
        spurious_d     = spurious_q;

        // The EOI clear goes first, so a same-cycle INTA1 set and the AEOI rotation override it.
        if (eoi_hit) begin
            isr_d[eoi_target] = 1'b0;
            if (rotateOnEoi) begin
                lowest_d = eoi_target;
            end
        end

        case (state_q)
            IDLE: begin
                if (qualify) begin
                    int_d   = 1'b1;
                    state_d = WAIT_INTA1;
                end
            end
            WAIT_INTA1: begin
                if (inta) begin
                    if (qualify) begin
                        level_d           = req_level;
                        spurious_d        = 1'b0;
                        isr_d[req_level]  = 1'b1;
                        clear_d[req_level] = 1'b1;
                    end else begin
                        level_d    = SPURIOUS_LEVEL;
                        spurious_d = 1'b1;
                    end
                    int_d   = 1'b0;
                    state_d = WAIT_INTA2;
                end
            end
            WAIT_INTA2: begin
                if (inta) begin
                    vector_d       = {vectorBase, level_q};
                    vector_valid_d = 1'b1;
                    if (autoEoi && !spurious_q) begin
                        isr_d[level_q] = 1'b0;
                        if (rotateOnAutoEoi) begin
                            lowest_d = level_q;
                        end
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            int_q          <= 1'b0;
            clear_q        <= '0;
            isr_q          <= '0;
            vector_q       <= '0;
            vector_valid_q <= 1'b0;
            lowest_q       <= 3'd7;
            level_q        <= '0;
            spurious_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            int_q          <= int_d;
            clear_q        <= clear_d;
            isr_q          <= isr_d;
            vector_q       <= vector_d;
            vector_valid_q <= vector_valid_d;
            lowest_q       <= lowest_d;
            level_q        <= level_d;
            spurious_q     <= spurious_d;
        end
    end

    assign intr                  = int_q;
    assign clearInterruptRequest = clear_q;
    assign inServiceRegister     = isr_q;
    assign vector                = vector_q;
    assign vectorValid           = vector_valid_q;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Scenario bench for interrupt_sequencer. Expected vectors are queued when a sequence starts
// and popped when vectorValid fires.
module tb_interrupt_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] irq;
    logic       inta;
    logic [4:0] vectorBase;
    logic       autoEoi;
    logic       rotateOnAutoEoi;
    logic       eoiStrobe;
    logic       specificEoi;
    logic [2:0] eoiLevel;
    logic       rotateOnEoi;
    logic       intr;
    logic [7:0] clearInterruptRequest;
    logic [7:0] inServiceRegister;
    logic [7:0] vector;
    logic       vectorValid;

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] exp_q[$];
    logic [7:0] expv;

    always #5 clk = ~clk;

    interrupt_sequencer #(.LEVELS(8)) dut (
        .clk                   (clk),
        .reset                 (reset),
        .irq                   (irq),
        .inta                  (inta),
        .vectorBase            (vectorBase),
        .autoEoi               (autoEoi),
        .rotateOnAutoEoi       (rotateOnAutoEoi),
        .eoiStrobe             (eoiStrobe),
        .specificEoi           (specificEoi),
        .eoiLevel              (eoiLevel),
        .rotateOnEoi           (rotateOnEoi),
        .intr                  (intr),
        .clearInterruptRequest (clearInterruptRequest),
        .inServiceRegister     (inServiceRegister),
        .vector                (vector),
        .vectorValid           (vectorValid)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_inta();
        inta = 1'b1;
        tick();
        inta = 1'b0;
    endtask

    task automatic do_eoi(input logic spec, input logic [2:0] lvl, input logic rot);
        eoiStrobe   = 1'b1;
        specificEoi = spec;
        eoiLevel    = lvl;
        rotateOnEoi = rot;
        tick();
        eoiStrobe   = 1'b0;
        specificEoi = 1'b0;
        eoiLevel    = 3'd0;
        rotateOnEoi = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (intr !== 1'b0) begin failures++; $display("FAIL reset_int got=%0b exp=0", intr); end
        checks++; if (clearInterruptRequest !== 8'h00) begin failures++; $display("FAIL reset_clear got=%h exp=00", clearInterruptRequest); end
        checks++; if (inServiceRegister !== 8'h00) begin failures++; $display("FAIL reset_isr got=%h exp=00", inServiceRegister); end
        checks++; if ({vectorValid, vector} !== 9'h000) begin failures++; $display("FAIL reset_vector got=%0b/%h exp=0/00", vectorValid, vector); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        irq = 8'h24;
        tick();
        checks++; if (intr !== 1'b1) begin failures++; $display("FAIL basic_int got=%0b exp=1", intr); end
        exp_q.push_back({5'h08, 3'd2});
        pulse_inta();
        irq = 8'h20;
        checks++; if (clearInterruptRequest !== 8'h04) begin failures++; $display("FAIL basic_clear got=%h exp=04", clearInterruptRequest); end
        checks++; if (inServiceRegister !== 8'h04) begin failures++; $display("FAIL basic_isr got=%h exp=04", inServiceRegister); end
        checks++; if (intr !== 1'b0) begin failures++; $display("FAIL basic_int_fall got=%0b exp=0", intr); end
        tick();
        checks++; if (clearInterruptRequest !== 8'h00) begin failures++; $display("FAIL basic_clear_width got=%h exp=00", clearInterruptRequest); end
        pulse_inta();
        expv = exp_q.pop_front();
        checks++; if ({vectorValid, vector} !== {1'b1, expv}) begin failures++; $display("FAIL basic_vector got=%0b/%h exp=1/%h", vectorValid, vector, expv); end
        tick();
        checks++; if ({vectorValid, vector} !== {1'b0, expv}) begin failures++; $display("FAIL basic_vector_hold got=%0b/%h exp=0/%h", vectorValid, vector, expv); end
        checks++; if (intr !== 1'b0) begin failures++; $display("FAIL basic_lower_blocked got=%0b exp=0", intr); end
        irq = 8'h00;
        do_eoi(1'b0, 3'd0, 1'b0);
        checks++; if (inServiceRegister !== 8'h00) begin failures++; $display("FAIL basic_eoi got=%h exp=00", inServiceRegister); end
    endtask

    task automatic test_nesting();
        irq = 8'h08;
        tick();
        exp_q.push_back({5'h08, 3'd3});
        pulse_inta();
        irq = 8'h00;
        pulse_inta();
        expv = exp_q.pop_front();
        checks++; if ({vectorValid, vector} !== {1'b1, expv}) begin failures++; $display("FAIL nest_vector3 got=%0b/%h exp=1/%h", vectorValid, vector, expv); end
        irq = 8'h28;
        tick();
        tick();
        checks++; if (intr !== 1'b0) begin failures++; $display("FAIL nest_blocked got=%0b exp=0", intr); end
        irq = 8'h02;
        tick();
        checks++; if (intr !== 1'b1) begin failures++; $display("FAIL nest_int got=%0b exp=1", intr); end
        exp_q.push_back({5'h08, 3'd1});
        pulse_inta();
        irq = 8'h00;
        checks++; if (clearInterruptRequest !== 8'h02) begin failures++; $display("FAIL nest_clear got=%h exp=02", clearInterruptRequest); end
        checks++; if (inServiceRegister !== 8'h0A) begin failures++; $display("FAIL nest_isr got=%h exp=0A", inServiceRegister); end
        pulse_inta();
        expv = exp_q.pop_front();
        checks++; if ({vectorValid, vector} !== {1'b1, expv}) begin failures++; $display("FAIL nest_vector1 got=%0b/%h exp=1/%h", vectorValid, vector, expv); end
        do_eoi(1'b0, 3'd0, 1'b0);
        checks++; if (inServiceRegister !== 8'h08) begin failures++; $display("FAIL nest_eoi_ceiling got=%h exp=08", inServiceRegister); end
        do_eoi(1'b0, 3'd0, 1'b0);
    endtask

    task automatic test_spurious();
        irq = 8'h10;
        tick();
        checks++; if (intr !== 1'b1) begin failures++; $display("FAIL spur_int got=%0b exp=1", intr); end
        irq = 8'h00;
        exp_q.push_back({5'h08, 3'd7});
        pulse_inta();
        checks++; if (clearInterruptRequest !== 8'h00) begin failures++; $display("FAIL spur_clear got=%h exp=00", clearInterruptRequest); end
        checks++; if (inServiceRegister !== 8'h00) begin failures++; $display("FAIL spur_isr got=%h exp=00", inServiceRegister); end
        pulse_inta();
        expv = exp_q.pop_front();
        checks++; if ({vectorValid, vector} !== {1'b1, expv}) begin failures++; $display("FAIL spur_vector got=%0b/%h exp=1/%h", vectorValid, vector, expv); end
    endtask

    task automatic test_aeoi_rotate();
        autoEoi         = 1'b1;
        rotateOnAutoEoi = 1'b1;
        irq = 8'h01;
        tick();
        exp_q.push_back({5'h08, 3'd0});
        pulse_inta();
        irq = 8'h00;
        checks++; if (inServiceRegister !== 8'h01) begin failures++; $display("FAIL aeoi_isr_set got=%h exp=01", inServiceRegister); end
        pulse_inta();
        expv = exp_q.pop_front();
        checks++; if ({vectorValid, vector} !== {1'b1, expv}) begin failures++; $display("FAIL aeoi_vector0 got=%0b/%h exp=1/%h", vectorValid, vector, expv); end
        checks++; if (inServiceRegister !== 8'h00) begin failures++; $display("FAIL aeoi_isr_clear got=%h exp=00", inServiceRegister); end
        irq = 8'h81;
        tick();
        exp_q.push_back({5'h08, 3'd7});
        pulse_inta();
        irq = 8'h01;
        checks++; if (clearInterruptRequest !== 8'h80) begin failures++; $display("FAIL aeoi_rotated_clear got=%h exp=80", clearInterruptRequest); end
        irq = 8'h00;
        pulse_inta();
        expv = exp_q.pop_front();
        checks++; if ({vectorValid, vector} !== {1'b1, expv}) begin failures++; $display("FAIL aeoi_vector7 got=%0b/%h exp=1/%h", vectorValid, vector, expv); end
        autoEoi         = 1'b0;
        rotateOnAutoEoi = 1'b0;
        tick();
    endtask

    task automatic test_eoi_forms();
        irq = 8'h10;
        tick();
        exp_q.push_back({5'h08, 3'd4});
        pulse_inta();
        irq = 8'h00;
        pulse_inta();
        expv = exp_q.pop_front();
        checks++; if ({vectorValid, vector} !== {1'b1, expv}) begin failures++; $display("FAIL eoi_vector4 got=%0b/%h exp=1/%h", vectorValid, vector, expv); end
        irq = 8'h02;
        tick();
        exp_q.push_back({5'h08, 3'd1});
        pulse_inta();
        irq = 8'h00;
        pulse_inta();
        expv = exp_q.pop_front();
        checks++; if ({vectorValid, vector} !== {1'b1, expv}) begin failures++; $display("FAIL eoi_vector1 got=%0b/%h exp=1/%h", vectorValid, vector, expv); end
        checks++; if (inServiceRegister !== 8'h12) begin failures++; $display("FAIL eoi_isr_setup got=%h exp=12", inServiceRegister); end
        do_eoi(1'b0, 3'd0, 1'b0);
        checks++; if (inServiceRegister !== 8'h10) begin failures++; $display("FAIL eoi_nonspecific got=%h exp=10", inServiceRegister); end
        do_eoi(1'b1, 3'd4, 1'b0);
        checks++; if (inServiceRegister !== 8'h00) begin failures++; $display("FAIL eoi_specific got=%h exp=00", inServiceRegister); end
        do_eoi(1'b0, 3'd0, 1'b1);
        checks++; if (inServiceRegister !== 8'h00) begin failures++; $display("FAIL eoi_empty got=%h exp=00", inServiceRegister); end
        // Unchanged priority still lets IR0 beat IR7.
        irq = 8'h81;
        tick();
        exp_q.push_back({5'h08, 3'd0});
        pulse_inta();
        irq = 8'h00;
        checks++; if (clearInterruptRequest !== 8'h01) begin failures++; $display("FAIL eoi_empty_no_rotate got=%h exp=01", clearInterruptRequest); end
        pulse_inta();
        expv = exp_q.pop_front();
        checks++; if ({vectorValid, vector} !== {1'b1, expv}) begin failures++; $display("FAIL eoi_vector0 got=%0b/%h exp=1/%h", vectorValid, vector, expv); end
        do_eoi(1'b0, 3'd0, 1'b1);
        irq = 8'h81;
        tick();
        exp_q.push_back({5'h08, 3'd7});
        pulse_inta();
        irq = 8'h00;
        checks++; if (clearInterruptRequest !== 8'h80) begin failures++; $display("FAIL eoi_rotate_clear got=%h exp=80", clearInterruptRequest); end
        pulse_inta();
        expv = exp_q.pop_front();
        checks++; if ({vectorValid, vector} !== {1'b1, expv}) begin failures++; $display("FAIL eoi_vector7 got=%0b/%h exp=1/%h", vectorValid, vector, expv); end
        do_eoi(1'b1, 3'd7, 1'b1);
        checks++; if (inServiceRegister !== 8'h00) begin failures++; $display("FAIL eoi_restore got=%h exp=00", inServiceRegister); end
    endtask

    task automatic test_same_cycle();
        irq = 8'h20;
        tick();
        exp_q.push_back({5'h08, 3'd5});
        pulse_inta();
        irq = 8'h00;
        pulse_inta();
        expv = exp_q.pop_front();
        checks++; if ({vectorValid, vector} !== {1'b1, expv}) begin failures++; $display("FAIL same_vector5 got=%0b/%h exp=1/%h", vectorValid, vector, expv); end
        irq = 8'h04;
        tick();
        checks++; if (intr !== 1'b1) begin failures++; $display("FAIL same_int got=%0b exp=1", intr); end
        exp_q.push_back({5'h08, 3'd2});
        inta        = 1'b1;
        eoiStrobe   = 1'b1;
        specificEoi = 1'b1;
        eoiLevel    = 3'd5;
        tick();
        inta        = 1'b0;
        eoiStrobe   = 1'b0;
        specificEoi = 1'b0;
        eoiLevel    = 3'd0;
        irq         = 8'h00;
        checks++; if (inServiceRegister !== 8'h04) begin failures++; $display("FAIL same_isr got=%h exp=04", inServiceRegister); end
        pulse_inta();
        expv = exp_q.pop_front();
        checks++; if ({vectorValid, vector} !== {1'b1, expv}) begin failures++; $display("FAIL same_vector2 got=%0b/%h exp=1/%h", vectorValid, vector, expv); end
        do_eoi(1'b0, 3'd0, 1'b0);
    endtask

    task automatic test_reset_mid();
        irq = 8'h08;
        tick();
        pulse_inta();
        irq = 8'h00;
        checks++; if (inServiceRegister !== 8'h08) begin failures++; $display("FAIL rmid_isr_before got=%h exp=08", inServiceRegister); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if ({intr, clearInterruptRequest, inServiceRegister, vector, vectorValid} !== 26'h0) begin
            failures++;
            $display("FAIL rmid_outputs got int=%0b clr=%h isr=%h vec=%h vv=%0b exp all 0", intr, clearInterruptRequest, inServiceRegister, vector, vectorValid);
        end
        pulse_inta();
        checks++; if ({vectorValid, vector} !== 9'h000) begin failures++; $display("FAIL rmid_no_vector got=%0b/%h exp=0/00", vectorValid, vector); end
        checks++; if (exp_q.size() !== 0) begin failures++; $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size()); end
    endtask

    initial begin
        reset           = 1'b1;
        irq             = 8'h00;
        inta            = 1'b0;
        vectorBase      = 5'h08;
        autoEoi         = 1'b0;
        rotateOnAutoEoi = 1'b0;
        eoiStrobe       = 1'b0;
        specificEoi     = 1'b0;
        eoiLevel        = 3'd0;
        rotateOnEoi     = 1'b0;
        tick();
        tick();
        test_reset();
        test_basic();
        test_nesting();
        test_spurious();
        test_aeoi_rotate();
        test_eoi_forms();
        test_same_cycle();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
